// File: rtl/seg7_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

    localparam int SEG_NIBBLE_W = 4;
    localparam int MAX_DIGITS   = 8;

    function automatic logic [MAX_DIGITS-1:0] digit_onehot(input logic [2:0] index);
        return MAX_DIGITS'(1) << index;
    endfunction

endpackage

// File: rtl/seg7_refresh_timer.sv
// Reloadable down-counter; tc is high while the count sits at zero.
module seg7_refresh_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/seg7_scan_controller.sv
// Multiplexed seven-segment scan: one digit lit at a time with a blanking gap,
// new display values committed only at frame boundaries or while idle.
//
//   state | meaning
//   IDLE  | scanning off, all digits dark, pending value committed immediately
//   SHOW  | digit[idx] lit for REFRESH_DIV cycles
//   BLANK | all digits dark for BLANK_CYCLES, then advance (wrap ends the frame)
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable,
    input  logic                             load_valid,
    output logic                             load_ready,
    input  logic [SEG_NIBBLE_W*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]            load_dots,
    output logic [SEG_NIBBLE_W-1:0]          nibble,
    output logic                             dot,
    output logic [NUM_DIGITS-1:0]            digit_en,
    output logic                             frame_done
);

    localparam int DATA_W  = SEG_NIBBLE_W * NUM_DIGITS;
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] SHOW_RELOAD  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_RELOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_DIGITS - 1);

    scan_state_t             state, state_nx;
    logic [IDX_W-1:0]        idx, idx_nx;
    logic [DATA_W-1:0]       active_data, active_data_nx, pending_data;
    logic [NUM_DIGITS-1:0]   active_dots, active_dots_nx, pending_dots;
    logic                    pending_valid;
    logic [NUM_DIGITS-1:0]   digit_en_nx;
    logic [SEG_NIBBLE_W-1:0] nibble_nx;
    logic                    dot_nx, frame_done_nx;
    logic                    accept, commit, light;
    logic                    timer_load, timer_tc;
    logic [CNT_W-1:0]        timer_value;

    assign load_ready = !pending_valid;
    assign accept     = load_valid && load_ready;

    seg7_refresh_timer #(.W(CNT_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (timer_value),
        .tc         (timer_tc)
    );

    always_comb begin
        state_nx      = state;
        idx_nx        = idx;
        timer_load    = 1'b0;
        timer_value   = SHOW_RELOAD;
        light         = 1'b0;
        commit        = 1'b0;
        digit_en_nx   = digit_en;
        frame_done_nx = 1'b0;

        case (state)
            IDLE: begin
                idx_nx      = '0;
                digit_en_nx = '0;
                commit      = pending_valid;
                if (enable) begin
                    state_nx   = SHOW;
                    timer_load = 1'b1;
                    light      = 1'b1;
                end
            end
            SHOW: begin
                if (!enable) begin
                    state_nx    = IDLE;
                    idx_nx      = '0;
                    digit_en_nx = '0;
                end else if (timer_tc) begin
                    state_nx    = BLANK;
                    timer_load  = 1'b1;
                    timer_value = BLANK_RELOAD;
                    digit_en_nx = '0;
                end
            end
            BLANK: begin
                if (!enable) begin
                    state_nx    = IDLE;
                    idx_nx      = '0;
                    digit_en_nx = '0;
                end else if (timer_tc) begin
                    state_nx   = SHOW;
                    timer_load = 1'b1;
                    light      = 1'b1;
                    if (idx == LAST_IDX) begin
                        idx_nx        = '0;
                        frame_done_nx = 1'b1;
                        commit        = pending_valid;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nx    = IDLE;
                idx_nx      = '0;
                digit_en_nx = '0;
            end
        endcase

        // The first digit of a frame must come from the freshly committed value.
        active_data_nx = commit ? pending_data : active_data;
        active_dots_nx = commit ? pending_dots : active_dots;

        nibble_nx = nibble;
        dot_nx    = dot;
        if (light) begin
            digit_en_nx = NUM_DIGITS'(digit_onehot(3'(idx_nx)));
            nibble_nx   = active_data_nx[{idx_nx, 2'b00} +: SEG_NIBBLE_W];
            dot_nx      = active_dots_nx[idx_nx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx           <= '0;
            active_data   <= '0;
            active_dots   <= '0;
            pending_data  <= '0;
            pending_dots  <= '0;
            pending_valid <= 1'b0;
            digit_en      <= '0;
            nibble        <= '0;
            dot           <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            idx         <= idx_nx;
            active_data <= active_data_nx;
            active_dots <= active_dots_nx;
            if (accept) begin
                pending_data <= load_data;
                pending_dots <= load_dots;
            end
            // Accept and commit never coincide: accept needs pending empty, commit needs it full.
            if (accept) begin
                pending_valid <= 1'b1;
            end else if (commit) begin
                pending_valid <= 1'b0;
            end
            digit_en   <= digit_en_nx;
            nibble     <= nibble_nx;
            dot        <= dot_nx;
            frame_done <= frame_done_nx;
        end
    end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seg7_scan_controller;

    localparam int N = 4;
    localparam int R = 8;
    localparam int B = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_data = '0;
    logic [3:0]  load_dots = '0;
    logic [3:0]  nibble;
    logic        dot;
    logic [3:0]  digit_en;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seg7_scan_controller #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (R),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_dots  (load_dots),
        .nibble     (nibble),
        .dot        (dot),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Starts at the negedge where digit 0 of a frame is lit (cycle 0); ends at cycle ncyc.
    // Up to two loads: each driven from its start cycle and held until load_ready.
    task automatic run_frame(input string tag, input logic [15:0] data, input logic [3:0] dots,
                             input int ncyc, input bit pend0,
                             input int at0, input logic [15:0] v0, input logic [3:0] d0,
                             input int at1, input logic [15:0] v1, input logic [3:0] d1,
                             output int acc0, output int acc1);
        bit pend;
        int slot;
        int d;
        int ph;
        pend = pend0;
        slot = 0;
        acc0 = -1;
        acc1 = -1;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            d  = cyc / (R + B);
            ph = cyc % (R + B);
            check($sformatf("%s.c%0d.digit_en", tag, cyc), digit_en, (ph < R) ? (32'd1 << d) : 32'd0);
            check($sformatf("%s.c%0d.nibble", tag, cyc), nibble, data[4*d +: 4]);
            check($sformatf("%s.c%0d.dot", tag, cyc), dot, dots[d]);
            if (cyc != 0) check($sformatf("%s.c%0d.frame_done", tag, cyc), frame_done, 0);
            check($sformatf("%s.c%0d.load_ready", tag, cyc), load_ready, !pend);
            if (slot == 0 && at0 >= 0 && cyc >= at0) begin
                load_valid = 1'b1; load_data = v0; load_dots = d0;
                if (load_ready) begin acc0 = cyc; pend = 1'b1; slot = 1; end
            end else if (slot == 1 && at1 >= 0 && cyc >= at1) begin
                load_valid = 1'b1; load_data = v1; load_dots = d1;
                if (load_ready) begin acc1 = cyc; pend = 1'b1; slot = 2; end
            end else begin
                load_valid = 1'b0;
            end
            step();
        end
    endtask

    task automatic check_wrap(input string tag, input logic [3:0] exp_nib, input logic exp_dot,
                              input logic exp_ready);
        check({tag, ".frame_done"}, frame_done, 1);
        check({tag, ".digit_en"}, digit_en, 4'b0001);
        check({tag, ".nibble"}, nibble, exp_nib);
        check({tag, ".dot"}, dot, exp_dot);
        check({tag, ".load_ready"}, load_ready, exp_ready);
    endtask

    initial begin
        int a0;
        int a1;

        // Reset state
        repeat (3) step();
        check("rst.digit_en", digit_en, 0);
        check("rst.nibble", nibble, 0);
        check("rst.dot", dot, 0);
        check("rst.frame_done", frame_done, 0);
        check("rst.load_ready", load_ready, 1);
        rst_n = 1'b1;
        step();

        // Idle load: ready low for exactly one cycle, digits stay dark
        load_valid = 1'b1; load_data = 16'h1234; load_dots = 4'b0000;
        check("idle.ready_pre", load_ready, 1);
        step();
        load_valid = 1'b0;
        check("idle.ready_low", load_ready, 0);
        check("idle.dig_a", digit_en, 0);
        step();
        check("idle.ready_back", load_ready, 1);
        check("idle.dig_b", digit_en, 0);
        repeat (3) step();
        check("idle.dig_c", digit_en, 0);
        check("idle.frame_done", frame_done, 0);

        // Load BEEF in idle, enable on the commit edge: first frame shows it
        load_valid = 1'b1; load_data = 16'hBEEF; load_dots = 4'b0100;
        step();
        load_valid = 1'b0; enable = 1'b1;
        check("scan.ready_low", load_ready, 0);
        step();
        run_frame("f1", 16'hBEEF, 4'b0100, 40, 1'b0, -1, '0, '0, -1, '0, '0, a0, a1);
        check_wrap("f1.wrap", 4'hF, 1'b0, 1'b1);

        // Mid-frame load of 0000 during digit 1
        run_frame("f2", 16'hBEEF, 4'b0100, 40, 1'b0, 12, 16'h0000, 4'b0000, -1, '0, '0, a0, a1);
        check("f2.acc", a0, 12);
        check_wrap("f2.wrap", 4'h0, 1'b0, 1'b1);

        // Back-pressure: second load held until the wrap frees the pending slot
        run_frame("f3", 16'h0000, 4'b0000, 40, 1'b0, 5, 16'h5678, 4'b0001, -1, '0, '0, a0, a1);
        check("f3.acc", a0, 5);
        check_wrap("f3.wrap", 4'h8, 1'b1, 1'b1);
        run_frame("f4", 16'h5678, 4'b0001, 40, 1'b0, 3, 16'h9ABC, 4'b1000, 20, 16'hDEAD, 4'b0010, a0, a1);
        check("f4.acc0", a0, 3);
        check("f4.acc1_blocked", a1, -1);
        check_wrap("f4.wrap", 4'hC, 1'b0, 1'b1);
        run_frame("f5", 16'h9ABC, 4'b1000, 40, 1'b0, 0, 16'hDEAD, 4'b0010, -1, '0, '0, a0, a1);
        check("f5.acc", a0, 0);
        check_wrap("f5.wrap", 4'hD, 1'b0, 1'b1);

        // Load accepted on the frame-wrap edge: shown one frame later
        run_frame("f6", 16'hDEAD, 4'b0010, 40, 1'b0, 39, 16'h0F0F, 4'b0101, -1, '0, '0, a0, a1);
        check("f6.acc", a0, 39);
        check_wrap("f6.wrap", 4'hD, 1'b0, 1'b0);
        run_frame("f7", 16'hDEAD, 4'b0010, 40, 1'b1, -1, '0, '0, -1, '0, '0, a0, a1);
        check_wrap("f7.wrap", 4'hF, 1'b1, 1'b1);

        // Abort during the blank after digit 2
        run_frame("f8", 16'h0F0F, 4'b0101, 28, 1'b0, -1, '0, '0, -1, '0, '0, a0, a1);
        check("abort.in_blank", digit_en, 0);
        enable = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            check($sformatf("abort.i%0d.digit_en", i), digit_en, 0);
            check($sformatf("abort.i%0d.frame_done", i), frame_done, 0);
        end
        enable = 1'b1;
        step();
        check("restart.frame_done", frame_done, 0);
        run_frame("f9", 16'h0F0F, 4'b0101, 3, 1'b0, -1, '0, '0, -1, '0, '0, a0, a1);

        // Asynchronous reset mid-SHOW
        rst_n = 1'b0;
        #1;
        check("arst.digit_en", digit_en, 0);
        check("arst.nibble", nibble, 0);
        check("arst.dot", dot, 0);
        check("arst.frame_done", frame_done, 0);
        check("arst.load_ready", load_ready, 1);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst.digit_en", digit_en, 4'b0001);
        check("post_rst.nibble", nibble, 0);
        check("post_rst.dot", dot, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
